fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Keeps a shadow scoreboard of the destination registers of instructions in EX, MEM and WB.
- Drives the 2-bit selects of the two EX-stage operand 3:1 muxes: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
- Raises a load-use stall, inserts a bubble, and counts stall cycles.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- CNT_WIDTH, 16, stall-cycle counter width.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_id_valid  input  1  ID stage holds a real instruction.
- i_id_rs1  input  REG_ADDR_WIDTH  ID source register 1.
- i_id_rs2  input  REG_ADDR_WIDTH  ID source register 2.
- i_id_rs1_used  input  1  instruction reads rs1.
- i_id_rs2_used  input  1  instruction reads rs2.
- i_id_rd  input  REG_ADDR_WIDTH  ID destination register.
- i_id_reg_write  input  1  instruction writes rd.
- i_id_is_load  input  1  instruction is a load.
- i_flush  input  1  taken branch/jump resolved in EX; squash the ID instruction.
- i_hold  input  1  global pipeline freeze (memory wait).
- o_fwd_a_sel  output  2  operand-A mux select, valid during EX.
- o_fwd_b_sel  output  2  operand-B mux select, valid during EX.
- o_stall  output  1  hold PC and IF/ID; bubble into EX.
- o_stall_cnt  output  CNT_WIDTH  saturating count of load-use stall cycles.

Behaviour:
- Reset (i_rst_n=0, async): all scoreboard valid bits 0; o_fwd_a_sel=o_fwd_b_sel=00; o_stall=0; o_stall_cnt=0.
- Scoreboard: three entries, ex/mem/wb, each holding {valid, rd, reg_write, is_load}. They advance on every rising edge where i_hold=0:
  - wb <= mem
  - mem <= ex
  - ex <= ID entry, or a bubble (valid=0).
- A producer qualifies only when valid=1, reg_write=1 and rd!=0. x0 is never forwarded.
- Forward selects are computed in ID against the current scoreboard and registered on the same edge as ex, so they are valid while the instruction is in EX. Per operand, when the operand is used and rs!=0:
  - rs==ex.rd (qualified): sel 01.
  - else rs==mem.rd (qualified): sel 10.
  - else: sel 00.
- EX match has priority over MEM match: most recent producer wins.
- A WB-stage producer needs no action. The register file writes in the first half-cycle, so an ID read returns the new value.
- Load-use hazard, combinational: o_stall=1 when all of the following hold:
  - i_id_valid=1 and i_flush=0;
  - ex.valid, ex.is_load and ex.reg_write are all 1, and ex.rd!=0;
  - ex.rd equals a used rs1 or a used rs2.
- During a stall, at the next non-hold edge:
  - ex <= bubble; both selects <= 00.
  - mem/wb advance normally.
  - The ID instruction stays put and is re-evaluated next cycle. Its load producer is then in mem, so it is forwarded via sel 10.
- Flush: i_flush=1 forces ex <= bubble and selects <= 00, and o_stall=0. Flush beats stall.
- i_id_valid=0 behaves as a bubble, with selects 00.
- i_hold=1 freezes the scoreboard, selects and counter. o_stall is still evaluated combinationally (the pipeline is frozen anyway).
- Counter: o_stall_cnt increments by 1 on each edge where o_stall=1 and i_hold=0, and saturates at all-ones.
- Mid-operation reset clears everything asynchronously. No forwarding happens from pre-reset producers.

Test Plan:
- Reset then no traffic -> o_fwd_a_sel=o_fwd_b_sel=00, o_stall=0, o_stall_cnt=0.
- add x5 then add x6,x5,x1 back-to-back -> consumer in EX sees a_sel=01, b_sel=00; with one independent instruction between them -> a_sel=10.
- add x5 followed by add x7,x5,x5 one behind and a second add x5 in between -> both selects 01 (EX priority over MEM).
- lw x5 then add x6,x0,x5 -> o_stall=1 for exactly one cycle with a bubble in EX (selects 00); add then enters EX with b_sel=10; o_stall_cnt=1.
- Producer writes x0 and consumer reads x0 -> selects stay 00, no stall. lw x5 with i_flush=1 on the consumer -> o_stall=0, selects 00.
- Load-use with i_hold=1 for 3 cycles -> scoreboard, selects and counter unchanged during the hold; one stall cycle is counted after the hold releases. Force the counter to max-1 and apply 2 stalls -> it saturates at all-ones.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-stage operand forwarding selects and load-use stall control for a 5-stage RV32I pipeline.
// Tracks the destination registers of the instructions in EX and MEM; a WB producer is covered by write-first register-file reads.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs2,
    input  logic                      i_id_rs1_used,
    input  logic                      i_id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rd,
    input  logic                      i_id_reg_write,
    input  logic                      i_id_is_load,
    input  logic                      i_flush,
    input  logic                      i_hold,
    output logic [1:0]                o_fwd_a_sel,
    output logic [1:0]                o_fwd_b_sel,
    output logic                      o_stall,
    output logic [CNT_WIDTH-1:0]      o_stall_cnt
);
    logic                      ex_valid_q, ex_rw_q, ex_ld_q;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_q;
    logic                      mem_valid_q, mem_rw_q;
    logic [REG_ADDR_WIDTH-1:0] mem_rd_q;
    logic [1:0]                sel_a_q, sel_b_q, sel_a_d, sel_b_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                      ex_fwd, mem_fwd, rs1_ex, rs2_ex, rs1_mem, rs2_mem, load_use, issue;

    // A producer only qualifies when it actually writes a non-x0 register.
    assign ex_fwd  = ex_valid_q & ex_rw_q & (ex_rd_q != '0);
    assign mem_fwd = mem_valid_q & mem_rw_q & (mem_rd_q != '0);
    assign rs1_ex  = i_id_rs1_used & ex_fwd & (i_id_rs1 == ex_rd_q);
    assign rs2_ex  = i_id_rs2_used & ex_fwd & (i_id_rs2 == ex_rd_q);
    assign rs1_mem = i_id_rs1_used & mem_fwd & (i_id_rs1 == mem_rd_q);
    assign rs2_mem = i_id_rs2_used & mem_fwd & (i_id_rs2 == mem_rd_q);

    assign load_use = i_id_valid & ~i_flush & ex_ld_q & (rs1_ex | rs2_ex);
    assign issue    = i_id_valid & ~i_flush & ~load_use;

    // Most recent producer (EX) wins over the older one (MEM).
    assign sel_a_d = ~issue ? 2'b00 : rs1_ex ? 2'b01 : rs1_mem ? 2'b10 : 2'b00;
    assign sel_b_d = ~issue ? 2'b00 : rs2_ex ? 2'b01 : rs2_mem ? 2'b10 : 2'b00;
    assign cnt_d   = (load_use && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_rw_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            ex_rd_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_rd_q    <= '0;
            sel_a_q     <= 2'b00;
            sel_b_q     <= 2'b00;
            cnt_q       <= '0;
        end else if (!i_hold) begin
            mem_valid_q <= ex_valid_q;
            mem_rw_q    <= ex_rw_q;
            mem_rd_q    <= ex_rd_q;
            ex_valid_q  <= issue;
            ex_rw_q     <= issue & i_id_reg_write;
            ex_ld_q     <= issue & i_id_is_load;
            ex_rd_q     <= issue ? i_id_rd : '0;
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            cnt_q       <= cnt_d;
        end
    end

    assign o_fwd_a_sel = sel_a_q;
    assign o_fwd_b_sel = sel_b_q;
    assign o_stall     = load_use;
    assign o_stall_cnt = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed self-checking bench for fwd_hazard_ctrl (counter narrowed to 3 bits to reach saturation quickly).
module tb_fwd_hazard_ctrl;
    localparam int CW = 3;
    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, rs1_used, rs2_used, reg_write, is_load, flush, hold;
    logic [4:0]    rs1, rs2, rd;
    logic [1:0]    a_sel, b_sel;
    logic          stall;
    logic [CW-1:0] cnt;
    int            checks = 0;
    int            errors = 0;

    fwd_hazard_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(id_valid),
        .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
        .i_id_rd(rd), .i_id_reg_write(reg_write), .i_id_is_load(is_load),
        .i_flush(flush), .i_hold(hold),
        .o_fwd_a_sel(a_sel), .o_fwd_b_sel(b_sel), .o_stall(stall), .o_stall_cnt(cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u1, input logic u2, input logic rw, input logic ld);
        id_valid = 1'b1; rd = d; rs1 = s1; rs2 = s2;
        rs1_used = u1; rs2_used = u2; reg_write = rw; is_load = ld;
        #1;
    endtask

    task automatic sels(input string tag, input logic [1:0] ea, input logic [1:0] eb);
        chk({tag, "_a"}, 8'(a_sel), 8'(ea));
        chk({tag, "_b"}, 8'(b_sel), 8'(eb));
    endtask

    task automatic load_use();
        put(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        put(5'd6, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
        rs1_used = 1'b0; rs2_used = 1'b0; reg_write = 1'b0; is_load = 1'b0;
        flush = 1'b0; hold = 1'b0;
        tick(); tick();
        sels("reset", 2'b00, 2'b00);
        chk("reset_stall", 8'(stall), 8'd0);
        chk("reset_cnt", 8'(cnt), 8'd0);
        rst_n = 1'b1;
        tick();
        sels("idle", 2'b00, 2'b00);

        put(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        sels("add_x5", 2'b00, 2'b00);
        put(5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("b2b_nostall", 8'(stall), 8'd0);
        tick();
        sels("b2b_ex", 2'b01, 2'b00);

        put(5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        put(5'd10, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        put(5'd11, 5'd8, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        sels("gap_mem", 2'b10, 2'b00);

        put(5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        put(5'd5, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        put(5'd7, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        sels("ex_prio", 2'b01, 2'b01);

        put(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        put(5'd6, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("lu_stall", 8'(stall), 8'd1);
        tick();
        sels("lu_bubble", 2'b00, 2'b00);
        chk("lu_cnt", 8'(cnt), 8'd1);
        chk("lu_stall_once", 8'(stall), 8'd0);
        tick();
        sels("lu_fwd", 2'b00, 2'b10);
        chk("lu_cnt_hold", 8'(cnt), 8'd1);

        put(5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1); tick();
        put(5'd12, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("x0_nostall", 8'(stall), 8'd0);
        tick();
        sels("x0_nofwd", 2'b00, 2'b00);

        put(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        put(5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        flush = 1'b1; #1;
        chk("flush_nostall", 8'(stall), 8'd0);
        tick();
        flush = 1'b0;
        sels("flush", 2'b00, 2'b00);
        chk("flush_cnt", 8'(cnt), 8'd1);

        put(5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        sels("pre_hold", 2'b10, 2'b00);
        put(5'd6, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        hold = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_stall", 8'(stall), 8'd1);
            tick();
            sels("hold_frozen", 2'b10, 2'b00);
            chk("hold_cnt", 8'(cnt), 8'd1);
        end
        hold = 1'b0; #1;
        chk("hold_rel_stall", 8'(stall), 8'd1);
        tick();
        sels("hold_bubble", 2'b00, 2'b00);
        chk("hold_rel_cnt", 8'(cnt), 8'd2);
        chk("hold_rel_nostall", 8'(stall), 8'd0);
        tick();
        sels("hold_fwd", 2'b10, 2'b00);

        repeat (4) load_use();
        chk("cnt_max_m1", 8'(cnt), 8'd6);
        load_use();
        chk("cnt_max", 8'(cnt), 8'd7);
        load_use();
        chk("cnt_sat", 8'(cnt), 8'd7);

        put(5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1); tick();
        rst_n = 1'b0; #1;
        sels("midrst", 2'b00, 2'b00);
        chk("midrst_cnt", 8'(cnt), 8'd0);
        tick();
        rst_n = 1'b1;
        put(5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("postrst_nostall", 8'(stall), 8'd0);
        tick();
        sels("postrst_nofwd", 2'b00, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
